// File: rtl/mac_sequencer_if.sv
// mac_sequencer_if: operand/result handshake bundle between the upstream source,
// the MAC sequencer and the operand/accumulator register enables.
// Ports: master = environment side (drives start/length/in_valid/out_ready),
//        slave  = sequencer side (drives ready/enables/status/count).
interface mac_sequencer_if #(
    parameter int LEN_WIDTH = 8
);
    logic                 start;
    logic [LEN_WIDTH-1:0] length;
    logic                 in_valid;
    logic                 in_ready;
    logic                 op_reg_enable;
    logic                 acc_clear;
    logic                 acc_enable;
    logic                 out_valid;
    logic                 out_ready;
    logic                 busy;
    logic [LEN_WIDTH-1:0] count;

    modport master (
        output start, length, in_valid, out_ready,
        input  in_ready, op_reg_enable, acc_clear, acc_enable, out_valid, busy, count
    );

    modport slave (
        input  start, length, in_valid, out_ready,
        output in_ready, op_reg_enable, acc_clear, acc_enable, out_valid, busy, count
    );
endinterface

// File: rtl/mac_sequencer.sv
// mac_sequencer: control FSM sequencing operand-register load, accumulator clear
// and accumulator update over one dot-product pass of `length` element pairs.
// Latency: result valid N+2 cycles after the start-sampling edge with no stalls.
// Backpressure: in_valid low stalls LOAD; out_ready low holds RESULT indefinitely.
// Ports: clk, reset (async active-low), bus (slave side of mac_sequencer_if):
//        start/length request, in_valid/in_ready operands, op_reg_enable,
//        acc_clear, acc_enable, out_valid/out_ready result, busy, count.
module mac_sequencer #(
    parameter int LEN_WIDTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    mac_sequencer_if.slave    bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LOAD,
        S_FLUSH,
        S_RESULT
    } state_t;

    state_t               state_q, state_d;
    logic [LEN_WIDTH-1:0] remaining_q, remaining_d;
    logic [LEN_WIDTH-1:0] count_q, count_d;
    logic                 acc_enable_q, acc_enable_d;
    logic                 accept;

    // A pair is taken only while loading; in_valid elsewhere is ignored.
    assign accept = (state_q == S_LOAD) && bus.in_valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            remaining_q  <= '0;
            count_q      <= '0;
            acc_enable_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            count_q      <= count_d;
            acc_enable_q <= acc_enable_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        remaining_d  = remaining_q;
        count_d      = count_q;
        // The product of an accepted pair is ready one cycle after the operand
        // registers load, so the accumulator enable is the accept delayed by one.
        acc_enable_d = accept;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    remaining_d = bus.length;
                    count_d     = '0;
                    state_d     = S_CLEAR;
                end
            end
            S_CLEAR: begin
                // Zero-length pass skips straight to a cleared result.
                state_d = (remaining_q != '0) ? S_LOAD : S_RESULT;
            end
            S_LOAD: begin
                if (accept) begin
                    remaining_d = remaining_q - LEN_WIDTH'(1);
                    count_d     = count_q + LEN_WIDTH'(1);
                    if (remaining_q == LEN_WIDTH'(1)) begin
                        state_d = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                // Cycle in which the last pair's acc_enable is issued.
                state_d = S_RESULT;
            end
            S_RESULT: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decode straight from registered state so reset clears them at once.
    assign bus.in_ready      = (state_q == S_LOAD);
    assign bus.op_reg_enable = accept;
    assign bus.acc_clear     = (state_q == S_CLEAR);
    assign bus.acc_enable    = acc_enable_q;
    assign bus.out_valid     = (state_q == S_RESULT);
    assign bus.busy          = (state_q != S_IDLE);
    assign bus.count         = count_q;

endmodule
